// File: rtl/ets_pkg.sv
// Shared types and helpers for the equivalent-time-sampling stream engine.
package ets_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACC,
        OUT,
        SHIFT,
        WAIT,
        HALT
    } ets_state_t;

    localparam logic [15:0] ETS_HDR_TAG = 16'hE75A;

    // Minimum width (at least 1) able to index 'value' entries.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/ets_bin_acc.sv
// One phase bin: saturating counter of 1-bit comparator samples.
module ets_bin_acc #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             sample,
    output logic [ACC_W-1:0] value
);

    // NOTE: the accumulator is ordinary state, so it is reset like any other
    // register; a run always re-clears it in ARM before use anyway.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= '0;
        end else if (enable && sample && (value != '1)) begin
            value <= value + ACC_W'(1);
        end
    end

endmodule

// File: rtl/ets_stream_engine.sv
// ETS engine: accumulates comparator samples into phase bins per vernier step, streams them on AXIS.
// Define ETS_STREAM_HEADER_EN to prefix each step's burst with a {ETS_HDR_TAG, step} header beat.
module ets_stream_engine
    import ets_pkg::*;
#(
    parameter int NUM_BINS = 10,
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic             sample_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_steps,
    input  logic [CNT_W-1:0] cfg_passes,
    input  logic             cmp_data,
    output logic             shift,
    input  logic             shift_done,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [ACC_W-1:0] m_tdata,
    output logic             m_tlast,
    output logic             busy,
    output logic             done
);

`ifdef ETS_STREAM_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int OUT_LEN = NUM_BINS + HDR;
    localparam int BIN_W   = clog2(NUM_BINS);
    localparam int WORD_W  = clog2(OUT_LEN);

    localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(NUM_BINS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(OUT_LEN - 1);

    ets_state_t        state, state_next;
    logic [CNT_W-1:0]  steps_q, passes_q, step_q, pass_q;
    logic [BIN_W-1:0]  bin_ptr;
    logic [WORD_W-1:0] word;
    logic              done_q;
    logic              beat, last_step;
    logic [ACC_W-1:0]  acc_val [NUM_BINS];

    assign beat      = m_tvalid && m_tready;
    assign last_step = (step_q == steps_q - CNT_W'(1));

    // NOTE: every output of this block is given a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ARM;
            ARM:     state_next = ACC;
            ACC:     if ((bin_ptr == LAST_BIN) && (pass_q == passes_q - CNT_W'(1))) state_next = OUT;
            OUT:     if (beat && (word == LAST_WORD)) state_next = last_step ? HALT : SHIFT;
            SHIFT:   state_next = WAIT;
            WAIT:    if (shift_done) state_next = ARM;
            HALT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignment so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state    <= IDLE;
            steps_q  <= '0;
            passes_q <= '0;
            step_q   <= '0;
            pass_q   <= '0;
            bin_ptr  <= '0;
            word     <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state == HALT);
            case (state)
                IDLE: if (start) begin
                    steps_q  <= (cfg_steps  == '0) ? CNT_W'(1) : cfg_steps;
                    passes_q <= (cfg_passes == '0) ? CNT_W'(1) : cfg_passes;
                    step_q   <= '0;
                end
                ARM: begin
                    bin_ptr <= '0;
                    pass_q  <= '0;
                    word    <= '0;
                end
                ACC: begin
                    if (bin_ptr == LAST_BIN) begin
                        bin_ptr <= '0;
                        pass_q  <= pass_q + CNT_W'(1);
                    end else begin
                        bin_ptr <= bin_ptr + BIN_W'(1);
                    end
                end
                OUT:     if (beat) word <= word + WORD_W'(1);
                WAIT:    if (shift_done) step_q <= step_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
        ets_bin_acc #(.ACC_W(ACC_W)) u_bin (
            .clk    (sample_clk),
            .reset  (reset),
            .clear  (state == ARM),
            .enable ((state == ACC) && (bin_ptr == BIN_W'(i))),
            .sample (cmp_data),
            .value  (acc_val[i])
        );
    end

    always_comb begin
        m_tdata = '0;
        if (state == OUT) begin
`ifdef ETS_STREAM_HEADER_EN
            if (word == '0) m_tdata = ACC_W'({ETS_HDR_TAG, 16'(step_q)});
            else            m_tdata = acc_val[word - WORD_W'(1)];
`else
            m_tdata = acc_val[word];
`endif
        end
    end

    assign m_tvalid = (state == OUT);
    assign m_tlast  = (state == OUT) && (word == LAST_WORD) && last_step;
    assign shift    = (state == SHIFT);
    assign busy     = (state != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_ets_stream_engine.sv
// Directed self-checking bench for ets_stream_engine (default 32-bit and an 8-bit saturation instance).
module tb_ets_stream_engine;

    localparam int NB = 10;
`ifdef ETS_STREAM_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int BURST = NB + HDR;

    logic        sample_clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_steps = '0, cfg_passes = '0;
    logic        cmp_data = 1'b0, shift_done = 1'b0, m_tready = 1'b1;
    logic        shift, m_tvalid, m_tlast, busy, done;
    logic [31:0] m_tdata;

    logic        start_b = 1'b0;
    logic        shift_b, m_tvalid_b, m_tlast_b, busy_b, done_b;
    logic [7:0]  m_tdata_b;

    int tests = 0, fails = 0;
    logic [31:0] beats[$];
    bit          lasts[$];
    int          shifts, dones;
    int          exp_bin[NB];

    always #5 sample_clk = ~sample_clk;

    ets_stream_engine #(.NUM_BINS(NB), .ACC_W(32), .CNT_W(16)) dut (
        .sample_clk(sample_clk), .reset(reset), .start(start),
        .cfg_steps(cfg_steps), .cfg_passes(cfg_passes), .cmp_data(cmp_data),
        .shift(shift), .shift_done(shift_done), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .busy(busy), .done(done)
    );

    ets_stream_engine #(.NUM_BINS(NB), .ACC_W(8), .CNT_W(16)) dut_b (
        .sample_clk(sample_clk), .reset(reset), .start(start_b),
        .cfg_steps(16'd1), .cfg_passes(16'd300), .cmp_data(1'b1),
        .shift(shift_b), .shift_done(1'b0), .m_tvalid(m_tvalid_b),
        .m_tready(1'b1), .m_tdata(m_tdata_b), .m_tlast(m_tlast_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [15:0] steps, input logic [15:0] passes);
        cfg_steps  = steps;
        cfg_passes = passes;
        start      = 1'b1;
        @(posedge sample_clk); #1;
        start      = 1'b0;
    endtask

    // Drives ready/shift_done, records accepted beats until done or timeout.
    task automatic run_collect(input bit rnd_ready, input int max_cycles);
        int          sd;
        bit          held_v;
        logic [31:0] held_d;
        sd = 0; held_v = 0; held_d = '0;
        beats.delete(); lasts.delete();
        shifts = 0; dones = 0;
        for (int c = 0; c < max_cycles && dones == 0; c++) begin
            @(negedge sample_clk);
            if (held_v) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_data", m_tdata, held_d);
            end
            held_v = m_tvalid && !m_tready;
            held_d = m_tdata;
            if (m_tvalid && m_tready) begin
                beats.push_back(m_tdata);
                lasts.push_back(m_tlast);
            end
            if (shift) begin
                shifts++;
                sd = 3;
            end
            if (done) dones++;
            @(posedge sample_clk); #1;
            m_tready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            shift_done = 1'b0;
            if (sd > 0) begin
                sd--;
                if (sd == 0) shift_done = 1'b1;
            end
        end
        check("done_seen", dones, 1);
        shift_done = 1'b0;
        m_tready   = 1'b1;
    endtask

    task automatic check_bursts(input int steps);
        int          total, s, j;
        logic [31:0] exp;
        total = steps * BURST;
        check("beat_count", beats.size(), total);
        for (int idx = 0; idx < beats.size(); idx++) begin
            s = idx / BURST;
            j = idx % BURST;
            if (HDR != 0 && j == 0) exp = {16'hE75A, 16'(s)};
            else                    exp = 32'(exp_bin[j - HDR]);
            check($sformatf("beat_data[%0d]", idx), beats[idx], exp);
            check($sformatf("beat_last[%0d]", idx), lasts[idx], (idx == total - 1));
        end
    endtask

    initial begin
        int          n, seen;
        logic [7:0]  bq[$];

        // Reset state
        repeat (2) @(posedge sample_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", m_tvalid, 0);
        check("rst_shift", shift, 0);
        check("rst_last", m_tlast, 0);
        check("rst_done", done, 0);
        check("rst_data", m_tdata, 0);
        reset = 1'b0;
        @(posedge sample_clk); #1;

        // 1: two steps of four passes, all-ones input
        foreach (exp_bin[i]) exp_bin[i] = 4;
        cmp_data = 1'b1;
        start_run(16'd2, 16'd4);
        run_collect(0, 500);
        check_bursts(2);
        check("t1_shifts", shifts, 1);
        @(negedge sample_clk);
        check("t1_idle", busy, 0);
        check("t1_done_pulse", done, 0);
        @(posedge sample_clk); #1;

        // 2: only phase 3 sees a one; ACC lasts exactly 50 cycles
        foreach (exp_bin[i]) exp_bin[i] = (i == 3) ? 5 : 0;
        cmp_data = 1'b0;
        start_run(16'd1, 16'd5);
        @(posedge sample_clk); #1;
        for (int k = 0; k < 5 * NB; k++) begin
            cmp_data = ((k % NB) == 3);
            if (k == 5 * NB - 1) check("t2_acc_not_done", m_tvalid, 0);
            @(posedge sample_clk); #1;
        end
        cmp_data = 1'b0;
        check("t2_acc_len", m_tvalid, 1);
        run_collect(0, 200);
        check_bursts(1);
        check("t2_shifts", shifts, 0);

        // 3: random backpressure
        foreach (exp_bin[i]) exp_bin[i] = 2;
        cmp_data = 1'b1;
        start_run(16'd2, 16'd2);
        run_collect(1, 1000);
        check_bursts(2);
        check("t3_shifts", shifts, 1);

        // 5: zero config means one pass of one step; restart while busy ignored
        foreach (exp_bin[i]) exp_bin[i] = 1;
        start_run(16'd0, 16'd0);
        repeat (2) @(posedge sample_clk);
        #1;
        start_run(16'd5, 16'd5);
        run_collect(0, 200);
        check_bursts(1);
        check("t5_shifts", shifts, 0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge sample_clk);
            if (busy || done) seen++;
        end
        check("t5_no_restart", seen, 0);
        @(posedge sample_clk); #1;

        // 6: reset during OUT abandons the stream
        m_tready = 1'b0;
        start_run(16'd1, 16'd1);
        n = 0;
        while (!m_tvalid && n < 100) begin
            @(posedge sample_clk); #1;
            n++;
        end
        check("t6_reached_out", m_tvalid, 1);
        reset = 1'b1;
        @(posedge sample_clk); #1;
        check("t6_valid", m_tvalid, 0);
        check("t6_busy", busy, 0);
        check("t6_data", m_tdata, 0);
        reset    = 1'b0;
        m_tready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sample_clk);
            if (done) seen++;
        end
        check("t6_no_done", seen, 0);
        @(posedge sample_clk); #1;

        // 4: 8-bit accumulators saturate after 300 passes
        start_b = 1'b1;
        @(posedge sample_clk); #1;
        start_b = 1'b0;
        seen = 0;
        for (int c = 0; c < 4000 && seen == 0; c++) begin
            @(negedge sample_clk);
            if (m_tvalid_b) bq.push_back(m_tdata_b);
            if (done_b) seen++;
        end
        check("t4_done", seen, 1);
        check("t4_count", bq.size(), BURST);
        for (int i = HDR; i < bq.size(); i++)
            check($sformatf("t4_sat[%0d]", i), bq[i], 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
